// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the ingress arbiter slice:
//   - NUM_PORTS          : number of ingress sources
//   - MAX_LEN_DEFAULT    : default maximum packet length in bytes (header included)
//   - GAP_CYCLES_DEFAULT : default number of forced idle cycles between packets
//   - HDR_PORT0..3       : the only header values that are forwarded
//   - arb_state_e        : arbiter FSM encoding (IDLE, FWD, DROP, GAP)
//   - hdr_is_valid()     : header range test
//   - onehot_to_idx()    : one-hot source vector to binary index
package router_pkg;

  localparam int NUM_PORTS          = 4;
  localparam int MAX_LEN_DEFAULT    = 16;
  localparam int GAP_CYCLES_DEFAULT = 2;

  localparam logic [7:0] HDR_PORT0 = 8'h00;
  localparam logic [7:0] HDR_PORT1 = 8'h01;
  localparam logic [7:0] HDR_PORT2 = 8'h02;
  localparam logic [7:0] HDR_PORT3 = 8'h03;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  // A header addresses one of the switch outputs; anything above the last
  // output number is unroutable.
  function automatic logic hdr_is_valid(input logic [7:0] hdr);
    return (hdr <= HDR_PORT3);
  endfunction

  // Returns the index of the set bit; zero when no bit is set.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (oh[k]) begin
        idx = 2'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// the pointer position and wrapping around, returning the first requester as
// a one-hot grant (all zero when nothing requests).
// Ports:
//   req_i [3:0] : request per source
//   ptr_i [1:0] : index the search starts from
//   gnt_o [3:0] : one-hot winner, or zero
module rr_pick
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [1:0]           ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  logic [1:0] idx_s;
  logic       found_s;

  // Walk the sources in rotated order; the 2-bit index wraps naturally.
  always_comb begin
    gnt_o   = 4'b0000;
    found_s = 1'b0;
    idx_s   = ptr_i;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx_s = ptr_i + 2'(k);
      if (!found_s && req_i[idx_s]) begin
        gnt_o[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ingress_arbiter.sv
// ingress_arbiter
// Shares one switch input between four byte-serial sources. A source holds
// src_valid for the whole packet; the first byte is the destination header.
// Packets with an unroutable header or longer than MAX_LEN are consumed but
// not (fully) forwarded. Successive packets are separated by GAP_CYCLES idle
// cycles. Arbitration is round-robin and non-preemptive.
// Ports:
//   clk              : clock, rising edge
//   reset            : asynchronous active-low reset
//   src_valid [3:0]  : per-source packet in progress
//   src_data  [31:0] : source i byte on bits [8i+7:8i]
//   src_ack   [3:0]  : byte of source i consumed this cycle (combinational)
//   grant     [3:0]  : one-hot current owner or zero (registered)
//   data_valid       : byte valid into the switch (registered)
//   data      [7:0]  : byte into the switch (registered, holds when idle)
//   len_err          : one-cycle pulse on a length overrun (registered)
module ingress_arbiter
  import router_pkg::*;
#(
  parameter int MAX_LEN    = MAX_LEN_DEFAULT,
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   src_valid,
  input  logic [8*NUM_PORTS-1:0] src_data,
  output logic [NUM_PORTS-1:0]   src_ack,
  output logic [NUM_PORTS-1:0]   grant,
  output logic                   data_valid,
  output logic [7:0]             data,
  output logic                   len_err
);

  // Counter must reach MAX_LEN itself, so it needs one more code than MAX_LEN-1.
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic                   dv_q, dv_d;
  logic [7:0]             data_q, data_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [GAP_W-1:0]       gap_q, gap_d;

  logic [NUM_PORTS-1:0]   pick_s;
  logic [1:0]             gidx_s;
  logic                   gvalid_s;
  logic [7:0]             gbyte_s;
  logic                   active_s;

  rr_pick u_rr_pick (
    .req_i (src_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_s)
  );

  // Selected source: its index, whether it is still sending, and its byte.
  always_comb begin
    gidx_s   = onehot_to_idx(grant_q);
    gvalid_s = |(grant_q & src_valid);
    gbyte_s  = src_data[{gidx_s, 3'b000} +: 8];
    active_s = (state_q == FWD) || (state_q == DROP);
  end

  // A byte is consumed whenever the owner presents one while forwarding or dropping.
  always_comb begin
    src_ack = grant_q & src_valid & {NUM_PORTS{active_s}};
  end

  // Next-state logic for the arbiter FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    dv_d    = 1'b0;
    data_d  = data_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;

    case (state_q)
      IDLE: begin
        if (|src_valid) begin
          // The pointer moves past the winner at grant time, so a packet
          // that turns out empty still costs that source its turn.
          grant_d = pick_s;
          ptr_d   = onehot_to_idx(pick_s) + 2'd1;
          cnt_d   = CNT_ZERO;
          state_d = FWD;
        end else begin
          grant_d = 4'b0000;
        end
      end

      FWD: begin
        if (gvalid_s) begin
          if (cnt_q == CNT_ZERO) begin
            if (hdr_is_valid(gbyte_s)) begin
              dv_d   = 1'b1;
              data_d = gbyte_s;
              cnt_d  = CNT_ONE;
            end else begin
              // Unroutable header: swallow it and the rest of the packet.
              state_d = DROP;
            end
          end else if (cnt_q < CNT_MAX) begin
            dv_d   = 1'b1;
            data_d = gbyte_s;
            cnt_d  = cnt_q + CNT_ONE;
          end else begin
            // Byte MAX_LEN+1: flag the overrun and discard the tail.
            err_d   = 1'b1;
            state_d = DROP;
          end
        end else begin
          grant_d = 4'b0000;
          cnt_d   = CNT_ZERO;
          if (cnt_q == CNT_ZERO) begin
            // Nothing was forwarded, so no gap is needed.
            state_d = IDLE;
          end else begin
            gap_d   = GAP_ZERO;
            state_d = GAP;
          end
        end
      end

      DROP: begin
        if (gvalid_s) begin
          state_d = DROP;
        end else begin
          grant_d = 4'b0000;
          cnt_d   = CNT_ZERO;
          gap_d   = GAP_ZERO;
          state_d = GAP;
        end
      end

      GAP: begin
        grant_d = 4'b0000;
        if (gap_q == GAP_LAST) begin
          gap_d   = GAP_ZERO;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end

      default: begin
        grant_d = 4'b0000;
        cnt_d   = CNT_ZERO;
        gap_d   = GAP_ZERO;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, counters, round-robin pointer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      dv_q    <= 1'b0;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
      cnt_q   <= CNT_ZERO;
      ptr_q   <= 2'd0;
      gap_q   <= GAP_ZERO;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
    end
  end

  assign grant      = grant_q;
  assign data_valid = dv_q;
  assign data       = data_q;
  assign len_err    = err_q;

endmodule

// File: tb/tb_ingress_arbiter.sv
module tb_ingress_arbiter;

  localparam int MAXL = 16;
  localparam int GAPC = 2;
  localparam int NP   = 8;
  localparam int NB   = 24;

  logic        clk;
  logic        reset;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_ack;
  logic [3:0]  grant;
  logic        data_valid;
  logic [7:0]  data;
  logic        len_err;

  int n_checks = 0;
  int n_errors = 0;

  // Source packet tables and per-source progress.
  int         npkt [4];
  int         plen [4][NP];
  logic [7:0] pbyte[4][NP][NB];
  int         pidx [4];
  int         bidx [4];
  bit         rest [4];
  logic [3:0] ack_smp;

  ingress_arbiter #(.MAX_LEN(MAXL), .GAP_CYCLES(GAPC)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ack    (src_ack),
    .grant      (grant),
    .data_valid (data_valid),
    .data       (data),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      npkt[i] = 0; pidx[i] = 0; bidx[i] = 0; rest[i] = 1'b0;
    end
    ack_smp = 4'b0000;
  endtask

  // Sources advance on the ack seen last cycle and rest one cycle between packets.
  task automatic drive_sources();
    for (int i = 0; i < 4; i++) begin
      if (ack_smp[i] && pidx[i] < npkt[i]) begin
        bidx[i]++;
        if (bidx[i] >= plen[i][pidx[i]]) begin
          pidx[i]++; bidx[i] = 0; rest[i] = 1'b1;
        end
      end else if (rest[i]) begin
        rest[i] = 1'b0;
      end
      if (pidx[i] < npkt[i] && !rest[i]) begin
        src_valid[i] = 1'b1;
        src_data[8*i +: 8] = pbyte[i][pidx[i]][bidx[i]];
      end else begin
        src_valid[i] = 1'b0;
        src_data[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    drive_sources();
    @(negedge clk);
    ack_smp = src_ack;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] stream[5];
    logic [7:0] hold;
    int k, found, dv_cnt, acks, rises;
    logic [3:0] first_g, prev_g;
    // reference model state for the random phase
    int exp_src[$];
    int exp_blen[$];
    logic [7:0] exp_bytes[$];
    int exp_err, taken[4], remaining, s, p, n, tot_len[4], ack_tot[4];
    int cur_len, low_run, err_seen, idle_cnt, done, total;
    logic prev_err;
    logic [7:0] last_d;

    // ---------------- reset values ----------------
    reset = 1'b0; src_valid = 4'b0000; src_data = 32'h0;
    clear_sources();
    #12;
    check_eq("rst_grant", grant, 4'b0000);
    check_eq("rst_dv", data_valid, 1'b0);
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_err", len_err, 1'b0);
    check_eq("rst_ack", src_ack, 4'b0000);
    reset = 1'b1;

    // ------- sources 0 and 2 together from reset -------
    clear_sources();
    npkt[0] = 1; plen[0][0] = 3;
    pbyte[0][0][0] = 8'h02; pbyte[0][0][1] = 8'hAA; pbyte[0][0][2] = 8'hBB;
    npkt[2] = 1; plen[2][0] = 2;
    pbyte[2][0][0] = 8'h01; pbyte[2][0][1] = 8'hCC;
    stream[0] = 8'h02; stream[1] = 8'hAA; stream[2] = 8'hBB; stream[3] = 8'h01; stream[4] = 8'hCC;
    hold = 8'h00; k = 0;
    for (int c = 0; c < 16; c++) begin
      logic       edv;
      logic [3:0] eg;
      next_cycle();
      // grant one cycle after request; bytes out one cycle after acceptance;
      // GAPC idle cycles plus one arbitration cycle between owners
      eg  = (c >= 1 && c <= 4) ? 4'b0001 : ((c >= 8 && c <= 10) ? 4'b0100 : 4'b0000);
      edv = (c inside {2, 3, 4, 9, 10});
      if (edv) begin hold = stream[k]; k++; end
      check_eq("b_grant", grant, eg);
      check_eq("b_dv", data_valid, edv);
      check_eq("b_data", data, hold);
      check_eq("b_err", len_err, 1'b0);
    end

    // ------- reset during the 3rd byte of a packet -------
    clear_sources();
    npkt[1] = 1; plen[1][0] = 5;
    pbyte[1][0][0] = 8'h01; pbyte[1][0][1] = 8'h11; pbyte[1][0][2] = 8'h22;
    pbyte[1][0][3] = 8'h33; pbyte[1][0][4] = 8'h44;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      next_cycle();
      if (bidx[1] == 2 && ack_smp[1]) found = 1;
    end
    check_eq("c_reach_3rd", found, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("c_rst_dv", data_valid, 1'b0);
    check_eq("c_rst_grant", grant, 4'b0000);
    check_eq("c_rst_data", data, 8'h00);
    check_eq("c_rst_ack", src_ack, 4'b0000);
    ack_smp = 4'b0000;
    @(posedge clk); #1; drive_sources();
    @(negedge clk);
    check_eq("c_hold_grant", grant, 4'b0000);
    #2 reset = 1'b1;
    ack_smp = src_ack;
    dv_cnt = 0; acks = 0; rises = 0; first_g = 4'b0000; prev_g = 4'b0000;
    for (int c = 0; c < 14; c++) begin
      next_cycle();
      dv_cnt += int'(data_valid);
      acks   += int'(ack_smp[1]);
      if (grant != 4'b0000 && prev_g == 4'b0000) begin
        rises++;
        if (rises == 1) first_g = grant;
      end
      prev_g = grant;
    end
    // remaining 22,33,44 form a packet with unroutable header 0x22
    check_eq("c_dv_after", dv_cnt, 0);
    check_eq("c_acks_after", acks, 3);
    check_eq("c_regrants", rises, 1);
    check_eq("c_regrant_src", first_g, 4'b0010);
    check_eq("c_src_done", pidx[1], 1);

    // ---------------- randomized traffic ----------------
    @(negedge clk); #2 reset = 1'b0; #2 reset = 1'b1;
    clear_sources();
    for (int i = 0; i < 4; i++) begin
      npkt[i] = $urandom_range(2, 4);
      for (int q = 0; q < npkt[i]; q++) begin
        plen[i][q] = $urandom_range(1, 20);
        for (int b = 0; b < NB; b++) pbyte[i][q][b] = 8'($urandom);
        if ($urandom_range(0, 9) < 7) pbyte[i][q][0] = 8'($urandom_range(0, 3));
        else                          pbyte[i][q][0] = 8'($urandom_range(4, 255));
      end
    end
    plen[1][0] = 4;  pbyte[1][0][0] = 8'h07;
    plen[3][0] = 20; pbyte[3][0][0] = 8'h01;

    // Model: everyone keeps requesting, so service is a plain rotation
    // 0,1,2,3,0,... skipping sources that have no packets left.
    exp_err = 0; remaining = 0; s = 0;
    for (int i = 0; i < 4; i++) begin
      taken[i] = 0; remaining += npkt[i]; tot_len[i] = 0; ack_tot[i] = 0;
      for (int q = 0; q < npkt[i]; q++) tot_len[i] += plen[i][q];
    end
    while (remaining > 0) begin
      if (taken[s] < npkt[s]) begin
        p = taken[s]; taken[s]++; remaining--;
        exp_src.push_back(s);
        if (pbyte[s][p][0] <= 8'h03) begin
          n = (plen[s][p] > MAXL) ? MAXL : plen[s][p];
          exp_blen.push_back(n);
          for (int b = 0; b < n; b++) exp_bytes.push_back(pbyte[s][p][b]);
          if (plen[s][p] > MAXL) exp_err++;
        end
      end
      s = (s + 1) % 4;
    end

    prev_g = 4'b0000; prev_err = 1'b0; last_d = 8'h00;
    cur_len = 0; low_run = 100; err_seen = 0; idle_cnt = 0; done = 0;
    for (int c = 0; c < 4000 && done == 0; c++) begin
      next_cycle();
      check_eq("d_onehot", $onehot0(grant), 1'b1);
      check_eq("d_ack_owner", src_ack & ~grant, 4'b0000);
      for (int i = 0; i < 4; i++) ack_tot[i] += int'(ack_smp[i]);
      if (grant != 4'b0000 && prev_g == 4'b0000) begin
        if (exp_src.size() > 0) check_eq("d_grant_order", grant, 4'b0001 << exp_src.pop_front());
        else                    check_eq("d_grant_extra", grant, 4'b0000);
      end
      prev_g = grant;
      if (data_valid) begin
        if (cur_len == 0) check_eq("d_gap", low_run >= GAPC, 1'b1);
        if (exp_bytes.size() > 0) check_eq("d_byte", data, exp_bytes.pop_front());
        else                      check_eq("d_byte_extra", data_valid, 1'b0);
        last_d = data;
        cur_len++;
      end else begin
        check_eq("d_data_hold", data, last_d);
        if (cur_len > 0) begin
          if (exp_blen.size() > 0) check_eq("d_burst_len", cur_len, exp_blen.pop_front());
          else                     check_eq("d_burst_extra", cur_len, 0);
          cur_len = 0; low_run = 0;
        end
        low_run++;
      end
      if (len_err) begin
        err_seen++;
        check_eq("d_err_width", prev_err, 1'b0);
      end
      prev_err = len_err;
      total = 0;
      for (int i = 0; i < 4; i++) total += (npkt[i] - pidx[i]);
      if (total == 0 && exp_src.size() == 0 && grant == 4'b0000 && !data_valid) idle_cnt++;
      else idle_cnt = 0;
      if (idle_cnt > GAPC + 3) done = 1;
    end
    check_eq("d_drained", done, 1);
    check_eq("d_err_count", err_seen, exp_err);
    check_eq("d_bytes_left", exp_bytes.size(), 0);
    check_eq("d_bursts_left", exp_blen.size(), 0);
    for (int i = 0; i < 4; i++) check_eq("d_ack_total", ack_tot[i], tot_len[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
